// File: rtl/test_port_writer_if.sv
// Store bus between the test-port writer and its sink.
// The writer drives addr/data/wen; the sink pushes back with stall.
interface test_port_writer_if;
    logic [29:0] addr;
    logic [31:0] data;
    logic        wen;
    logic        stall;

    modport master (output addr, data, wen, input stall);
    modport slave  (input addr, data, wen, output stall);
endinterface

// File: rtl/test_port_writer.sv
// Test-port writer: emits BEGIN_SYM, an ascending then descending run of
// Fibonacci-derived words F(k)+j, then END_SYM, each store followed by GAP
// idle cycles so every store shows a fresh wen edge.
// Optional feature: define TPW_ERR_INJECT_EN to flip data bit 0 on store INJECT_IDX.
module test_port_writer #(
    parameter int          N_FIB     = 20,
    parameter logic [29:0] TEST_PORT = 30'hFF,
    parameter logic [31:0] BEGIN_SYM = 32'h00000932,
    parameter logic [31:0] END_SYM   = 32'h00000D5D,
    parameter int          GAP       = 1
`ifdef TPW_ERR_INJECT_EN
    ,
    parameter int          INJECT_IDX = 5
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    test_port_writer_if.master         bus,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_BEGIN, ST_ASC, ST_DESC, ST_END, ST_GAPW, ST_DONE
    } state_t;

    localparam logic [5:0] K_LAST   = 6'(N_FIB - 1);
    localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

    state_t      state, next_state, ret_state;
    logic [31:0] fa, fb;     // fa = F(k), fb = F(k+1)
    logic [5:0]  k;
    logic [1:0]  j;
    logic [3:0]  gap_cnt;
    logic        accept;
    logic        wen_c;

    assign accept = wen_c && !bus.stall;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state logic; GAPW resumes whatever state the last store selected
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE:                  if (start) next_state = ST_BEGIN;
            ST_BEGIN, ST_ASC, ST_DESC, ST_END: if (accept) next_state = ST_GAPW;
            ST_GAPW:                           if (gap_cnt == 4'd0) next_state = ret_state;
            default:                           next_state = ST_IDLE;
        endcase
    end

    // Fibonacci pair, term/offset counters, gap timer and return state
    always_ff @(posedge clk) begin
        if (rst) begin
            fa        <= '0;
            fb        <= '0;
            k         <= '0;
            j         <= '0;
            gap_cnt   <= '0;
            ret_state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        fa <= 32'd0;
                        fb <= 32'd1;
                        k  <= '0;
                        j  <= '0;
                    end
                end
                ST_BEGIN: begin
                    if (accept) begin
                        gap_cnt   <= GAP_LOAD;
                        ret_state <= ST_ASC;
                    end
                end
                ST_ASC: begin
                    if (accept) begin
                        gap_cnt   <= GAP_LOAD;
                        ret_state <= ST_ASC;
                        if (j == 2'd3) begin
                            // Last term: DESC starts on the same term, j stays 3
                            if (k == K_LAST) begin
                                ret_state <= ST_DESC;
                            end else begin
                                fa <= fb;
                                fb <= fa + fb;
                                k  <= k + 6'd1;
                                j  <= 2'd0;
                            end
                        end else begin
                            j <= j + 2'd1;
                        end
                    end
                end
                ST_DESC: begin
                    if (accept) begin
                        gap_cnt   <= GAP_LOAD;
                        ret_state <= ST_DESC;
                        if (j == 2'd0) begin
                            if (k == 6'd0) begin
                                ret_state <= ST_END;
                            end else begin
                                fa <= fb - fa;
                                fb <= fa;
                                k  <= k - 6'd1;
                                j  <= 2'd3;
                            end
                        end else begin
                            j <= j - 2'd1;
                        end
                    end
                end
                ST_END: begin
                    if (accept) begin
                        gap_cnt   <= GAP_LOAD;
                        ret_state <= ST_DONE;
                    end
                end
                ST_GAPW: begin
                    if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef TPW_ERR_INJECT_EN
    logic [9:0] st_idx;

    // Index of the store currently presented, BEGIN_SYM = 0
    always_ff @(posedge clk) begin
        if (rst)                                                st_idx <= '0;
        else if ((state == ST_IDLE || state == ST_DONE) && start) st_idx <= '0;
        else if (accept)                                        st_idx <= st_idx + 10'd1;
    end
`endif

    // Outputs decoded from state; stable under stall since nothing advances
    always_comb begin
        wen_c     = (state == ST_BEGIN) || (state == ST_ASC) ||
                    (state == ST_DESC)  || (state == ST_END);
        busy      = (state != ST_IDLE) && (state != ST_DONE);
        done      = (state == ST_DONE);
        bus.wen   = wen_c;
        bus.addr  = busy ? TEST_PORT : 30'd0;
        bus.data  = 32'd0;
        case (state)
            ST_BEGIN:        bus.data = BEGIN_SYM;
            ST_ASC, ST_DESC: bus.data = fa + {30'd0, j};
            ST_END:          bus.data = END_SYM;
            default:         bus.data = 32'd0;
        endcase
`ifdef TPW_ERR_INJECT_EN
        if (wen_c && (st_idx == 10'(INJECT_IDX))) bus.data[0] = ~bus.data[0];
`endif
    end

endmodule

// File: tb/tb_test_port_writer.sv
// Directed bench for test_port_writer with default parameters.
module tb_test_port_writer;
    localparam int N_FIB = 20;
    localparam int NST   = 8 * N_FIB + 2;

    logic clk = 1'b0;
    logic rst, start, busy, done;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic [31:0] expv [NST];
    logic [31:0] acc_data [$];
    int          acc_cyc  [$];

    test_port_writer_if bus();

    test_port_writer dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus.master),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Log every accepted store with the cycle it was accepted in
    always @(posedge clk) begin
        if (bus.wen && !bus.stall && !rst) begin
            acc_data.push_back(bus.data);
            acc_cyc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin
                dc = cyc;
                break;
            end
            tick();
        end
        if (dc < 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_seq(input string tag, input int base, input bit timed, input int t0);
        int n, errs, terrs;
        n = acc_data.size() - base;
        errs = 0;
        terrs = 0;
        chk({tag, "_count"}, 64'(n), 64'(NST));
        for (int i = 0; i < NST && i < n; i++) begin
            if (acc_data[base + i] !== expv[i]) errs++;
            if (acc_cyc[base + i] != t0 + 1 + 2 * i) terrs++;
        end
        chk({tag, "_data_errs"}, 64'(errs), 64'd0);
        if (timed) chk({tag, "_timing_errs"}, 64'(terrs), 64'd0);
        if (n >= NST) begin
            for (int i = 77; i <= 84; i++)
                chk($sformatf("%s_store%0d", tag, i), 64'(acc_data[base + i]),
                    64'(i <= 80 ? 4181 + (i - 77) : 4184 - (i - 81)));
            for (int i = 157; i <= 160; i++)
                chk($sformatf("%s_store%0d", tag, i), 64'(acc_data[base + i]), 64'(160 - i));
`ifdef TPW_ERR_INJECT_EN
            chk({tag, "_store5"}, 64'(acc_data[base + 5]), 64'd0);
`else
            chk({tag, "_store5"}, 64'(acc_data[base + 5]), 64'd1);
`endif
            chk({tag, "_first"}, 64'(acc_data[base]), 64'h932);
            chk({tag, "_last"}, 64'(acc_data[base + NST - 1]), 64'hD5D);
        end
    endtask

    initial begin
        logic [31:0] f [N_FIB];
        logic [62:0] held;
        int t0, base, dc, idx;

        // Reference sequence from a plain Fibonacci table
        f[0] = 0;
        f[1] = 1;
        for (int i = 2; i < N_FIB; i++) f[i] = f[i-1] + f[i-2];
        idx = 0;
        expv[idx++] = 32'h932;
        for (int kk = 0; kk < N_FIB; kk++)
            for (int jj = 0; jj < 4; jj++) expv[idx++] = f[kk] + 32'(jj);
        for (int kk = N_FIB - 1; kk >= 0; kk--)
            for (int jj = 3; jj >= 0; jj--) expv[idx++] = f[kk] + 32'(jj);
        expv[idx] = 32'hD5D;

        // Reset state
        rst = 1'b1; start = 1'b0; bus.stall = 1'b0;
        repeat (3) tick();
        chk("rst_wen",  64'(bus.wen),  64'd0);
        chk("rst_busy", 64'(busy),     64'd0);
        chk("rst_done", 64'(done),     64'd0);
        chk("rst_addr", 64'(bus.addr), 64'd0);
        chk("rst_data", 64'(bus.data), 64'd0);
        rst = 1'b0;
        tick();

        // A: uninterrupted run, timing and content
        base = acc_data.size();
        t0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("a_begin_wen",  64'(bus.wen),  64'd1);
        chk("a_begin_data", 64'(bus.data), 64'h932);
        chk("a_begin_addr", 64'(bus.addr), 64'hFF);
        chk("a_begin_busy", 64'(busy),     64'd1);
        chk("a_begin_done", 64'(done),     64'd0);
        tick();
        chk("a_gap_wen",  64'(bus.wen),  64'd0);
        chk("a_gap_data", 64'(bus.data), 64'd0);
        chk("a_gap_busy", 64'(busy),     64'd1);
        wait_done(dc);
        chk("a_done_cycle", 64'(dc - t0), 64'd325);
        check_seq("a", base, 1'b1, t0);
        chk("a_idle_busy", 64'(busy),     64'd0);
        chk("a_idle_addr", 64'(bus.addr), 64'd0);
        chk("a_idle_wen",  64'(bus.wen),  64'd0);
        repeat (3) tick();
        chk("a_done_hold", 64'(done), 64'd1);

        // B: stall on store 3, restart from DONE, start while busy
        base = acc_data.size();
        t0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b_restart_done", 64'(done), 64'd0);
        repeat (6) tick();
        chk("b_s3_wen",  64'(bus.wen),  64'd1);
        chk("b_s3_data", 64'(bus.data), 64'(expv[3]));
        held = {bus.wen, bus.addr, bus.data};
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("b_stall_hold%0d", i), 64'({bus.wen, bus.addr, bus.data}), 64'(held));
        end
        tick();
        bus.stall = 1'b0;
        chk("b_stall_hold4", 64'({bus.wen, bus.addr, bus.data}), 64'(held));
        tick();
        chk("b_accepts", 64'(acc_data.size() - base), 64'd4);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b_s4_wen",  64'(bus.wen),  64'd1);
        chk("b_s4_data", 64'(bus.data), 64'(expv[4]));
        chk("b_s4_busy", 64'(busy),     64'd1);
        wait_done(dc);
        check_seq("b", base, 1'b0, t0);

        // C: reset in DESC, then full rerun
        base = acc_data.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 1000 && (acc_data.size() - base) < 100; i++) tick();
        chk("c_in_desc", 64'(acc_data.size() - base >= 100), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("c_rst_wen",  64'(bus.wen),  64'd0);
        chk("c_rst_busy", 64'(busy),     64'd0);
        chk("c_rst_done", 64'(done),     64'd0);
        chk("c_rst_data", 64'(bus.data), 64'd0);
        chk("c_rst_addr", 64'(bus.addr), 64'd0);
        tick();
        base = acc_data.size();
        t0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(dc);
        chk("c_done_cycle", 64'(dc - t0), 64'd325);
        check_seq("c", base, 1'b1, t0);

        // D: start and rst together stays idle
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        tick();
        chk("d_busy", 64'(busy),    64'd0);
        chk("d_wen",  64'(bus.wen), 64'd0);
        chk("d_done", 64'(done),    64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
